// File: rtl/wf_button_gesture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wf_button_gesture_pkg
// Purpose  : Shared time base and types for the button gesture classifier.
// Revision : 1.0
// ============================================================================
package wf_button_gesture_pkg;

    // Period of the sample tick; fpga_top derives its tick divider from this.
    localparam int c_TICK_PERIOD_MS = 10;

    localparam int                 c_CNT_W   = 10;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    typedef struct packed {
        logic short_press;
        logic double_press;
        logic long_press;
        logic repeat_pulse;
    } gesture_pulses_t;

    // Count value on which the Nth tick lands (counter starts at zero).
    function automatic logic [c_CNT_W-1:0] terminal_count(input int ticks);
        if (ticks < 1)
            return '0;
        return c_CNT_W'(ticks - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wf_button_gesture.sv
`default_nettype none
// ============================================================================
// Module   : wf_button_gesture
// Purpose  : Classifies debounced presses into short/double/long gestures and
//            emits auto-repeat pulses while a long press is held.
// Revision : 1.0
// ============================================================================
module wf_button_gesture
    import wf_button_gesture_pkg::*;
#(
    parameter int LONG_TICKS       = 100,
    parameter int DOUBLE_GAP_TICKS = 30,
    parameter int REPEAT_TICKS     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic switch_pushed,
    input  logic switch_released,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_PRESS1    = 3'd1;
    localparam logic [2:0] c_WAIT2     = 3'd2;
    localparam logic [2:0] c_PRESS2    = 3'd3;
    localparam logic [2:0] c_LONG_HOLD = 3'd4;

    localparam logic [c_CNT_W-1:0] c_LONG_TC   = terminal_count(LONG_TICKS);
    localparam logic [c_CNT_W-1:0] c_GAP_TC    = terminal_count(DOUBLE_GAP_TICKS);
    localparam logic [c_CNT_W-1:0] c_REPEAT_TC = terminal_count(REPEAT_TICKS);
    localparam bit                 c_REPEAT_EN = (REPEAT_TICKS != 0);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    gesture_pulses_t    w_pulses;
    gesture_pulses_t    r_pulses;
    logic               r_held;

    logic w_rel;
    logic w_push;
    logic w_tick;

    // A release masks a coincident push; any edge swallows a coincident tick.
    assign w_rel  = switch_released;
    assign w_push = switch_pushed & ~switch_released;
    assign w_tick = tick & ~switch_pushed & ~switch_released;

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_pulses     = '0;
        case (r_state)
            c_IDLE: begin
                if (w_push) begin
                    w_next_state = c_PRESS1;
                    w_cnt_clr    = 1'b1;
                end
            end
            c_PRESS1: begin
                if (w_rel) begin
                    w_next_state = c_WAIT2;
                    w_cnt_clr    = 1'b1;
                end else if (w_tick) begin
                    if (r_cnt == c_LONG_TC) begin
                        w_pulses.long_press = 1'b1;
                        w_next_state        = c_LONG_HOLD;
                        w_cnt_clr           = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            c_WAIT2: begin
                if (w_push) begin
                    w_next_state = c_PRESS2;
                    w_cnt_clr    = 1'b1;
                end else if (w_tick) begin
                    if (r_cnt == c_GAP_TC) begin
                        w_pulses.short_press = 1'b1;
                        w_next_state         = c_IDLE;
                        w_cnt_clr            = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            c_PRESS2: begin
                if (w_rel) begin
                    w_pulses.double_press = 1'b1;
                    w_next_state          = c_IDLE;
                    w_cnt_clr             = 1'b1;
                end else if (w_tick) begin
                    // Holding the second press past the long threshold wins over the double.
                    if (r_cnt == c_LONG_TC) begin
                        w_pulses.long_press = 1'b1;
                        w_next_state        = c_LONG_HOLD;
                        w_cnt_clr           = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            c_LONG_HOLD: begin
                if (w_rel) begin
                    w_next_state = c_IDLE;
                    w_cnt_clr    = 1'b1;
                end else if (w_tick && c_REPEAT_EN) begin
                    if (r_cnt == c_REPEAT_TC) begin
                        w_pulses.repeat_pulse = 1'b1;
                        w_cnt_clr             = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = c_IDLE;
                w_cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset || w_cnt_clr)
            r_cnt <= '0;
        else if (w_cnt_inc && (r_cnt != c_CNT_MAX))
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulses <= '0;
            r_held   <= 1'b0;
        end else begin
            r_pulses <= w_pulses;
            r_held   <= (w_next_state == c_PRESS1) ||
                        (w_next_state == c_PRESS2) ||
                        (w_next_state == c_LONG_HOLD);
        end
    end

    assign short_press  = r_pulses.short_press;
    assign double_press = r_pulses.double_press;
    assign long_press   = r_pulses.long_press;
    assign repeat_pulse = r_pulses.repeat_pulse;
    assign held         = r_held;

endmodule
`default_nettype wire

// File: tb/tb_wf_button_gesture.sv
`default_nettype none
// ============================================================================
// Module   : tb_wf_button_gesture
// Purpose  : Scoreboard bench for wf_button_gesture (LONG=5, GAP=3, REPEAT=2).
// Revision : 1.0
// ============================================================================
module tb_wf_button_gesture;

    localparam int c_TICK_DIV = 10;

    // Pulse vector bit order: {repeat, long, double, short}
    localparam logic [3:0] c_NONE   = 4'b0000;
    localparam logic [3:0] c_SHORT  = 4'b0001;
    localparam logic [3:0] c_DOUBLE = 4'b0010;
    localparam logic [3:0] c_LONG   = 4'b0100;
    localparam logic [3:0] c_REPEAT = 4'b1000;

    typedef struct packed {
        logic       held;
        logic [3:0] pulses;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic switch_pushed = 1'b0;
    logic switch_released = 1'b0;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    exp_t  sb_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    phase = 0;
    int    cycle = 0;
    string scen = "init";

    wf_button_gesture #(
        .LONG_TICKS      (5),
        .DOUBLE_GAP_TICKS(3),
        .REPEAT_TICKS    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .switch_pushed  (switch_pushed),
        .switch_released(switch_released),
        .short_press    (short_press),
        .double_press   (double_press),
        .long_press     (long_press),
        .repeat_pulse   (repeat_pulse),
        .held           (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s/%s @cycle %0d: got %0h expected %0h", scen, tag, cycle, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue the expectation, then compare after the edge.
    task automatic cyc(input logic p, input logic r, input logic rs,
                       input logic eh, input logic [3:0] ep);
        exp_t e;
        sb_q.push_back('{held: eh, pulses: ep});
        switch_pushed   = p;
        switch_released = r;
        reset           = rs;
        tick            = (phase == c_TICK_DIV - 1);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pulses", {4'b0, repeat_pulse, long_press, double_press, short_press},
              {4'b0, e.pulses});
        check("held", {7'b0, held}, {7'b0, e.held});
        switch_pushed   = 1'b0;
        switch_released = 1'b0;
        reset           = 1'b0;
        tick            = 1'b0;
        phase           = (phase + 1) % c_TICK_DIV;
        cycle++;
    endtask

    // Idle until the next call to cyc() will carry a tick.
    task automatic to_pre_tick(input logic eh);
        while (phase != c_TICK_DIV - 1)
            cyc(1'b0, 1'b0, 1'b0, eh, c_NONE);
    endtask

    task automatic idle_tick(input logic eh, input logic [3:0] ep);
        to_pre_tick(eh);
        cyc(1'b0, 1'b0, 1'b0, eh, ep);
    endtask

    task automatic push(input logic eh);
        cyc(1'b1, 1'b0, 1'b0, eh, c_NONE);
    endtask

    task automatic release_btn(input logic [3:0] ep);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, ep);
    endtask

    initial begin
        scen = "reset";
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);

        scen = "short";
        push(1'b1);
        idle_tick(1'b1, c_NONE);
        idle_tick(1'b1, c_NONE);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_SHORT);
        idle_tick(1'b0, c_NONE);

        scen = "double";
        push(1'b1);
        idle_tick(1'b1, c_NONE);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);
        push(1'b1);
        idle_tick(1'b1, c_NONE);
        release_btn(c_DOUBLE);
        for (int i = 0; i < 4; i++) idle_tick(1'b0, c_NONE);

        scen = "long";
        push(1'b1);
        for (int t = 1; t <= 11; t++) begin
            if (t == 5)
                idle_tick(1'b1, c_LONG);
            else if (t == 7 || t == 9 || t == 11)
                idle_tick(1'b1, c_REPEAT);
            else
                idle_tick(1'b1, c_NONE);
        end
        release_btn(c_NONE);
        for (int i = 0; i < 3; i++) idle_tick(1'b0, c_NONE);

        scen = "late_push";
        push(1'b1);
        idle_tick(1'b1, c_NONE);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_SHORT);
        push(1'b1);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_SHORT);

        scen = "push_on_tick";
        push(1'b1);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);
        to_pre_tick(1'b0);
        push(1'b1);
        for (int i = 0; i < 4; i++) idle_tick(1'b1, c_NONE);
        idle_tick(1'b1, c_LONG);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);

        scen = "reset_mid";
        push(1'b1);
        release_btn(c_NONE);
        push(1'b1);
        for (int i = 0; i < 3; i++) idle_tick(1'b1, c_NONE);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, c_NONE);
        release_btn(c_NONE);
        for (int i = 0; i < 6; i++) idle_tick(1'b0, c_NONE);
        push(1'b1);
        release_btn(c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_SHORT);

        scen = "push_and_release";
        push(1'b1);
        idle_tick(1'b1, c_NONE);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_NONE);
        idle_tick(1'b0, c_SHORT);
        idle_tick(1'b0, c_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
